// File: rtl/lsu_bus_master.sv
// MEM-stage load/store unit driving a word-wide req/ack data bus, with read-modify-write for sb/sh.
// Define LSU_BUS_TIMEOUT_EN to enable the per-beat watchdog (TIMEOUT_CYCLES).
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [4:0]  mem_op_l,
  input  logic [4:0]  mem_op_s,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        stall,
  output logic        misalign,
  output logic        bus_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B} size_t;

  state_t      state;
  size_t       size_c;
  logic        sext_c;
  logic        mis_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;
  logic [31:0] merge_c;

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("lsu_bus_master: TIMEOUT_CYCLES must be nonzero");
  end

  // Access size and signedness from the op code of the active direction.
  always_comb begin
    size_c = SZ_W;
    sext_c = 1'b0;
    if (cpu_we) begin
      case (mem_op_s)
        5'd1:    size_c = SZ_B;
        5'd2:    size_c = SZ_H;
        default: size_c = SZ_W;
      endcase
    end else begin
      case (mem_op_l)
        5'd1:    size_c = SZ_B;
        5'd2:    size_c = SZ_H;
        5'd3:    begin size_c = SZ_B; sext_c = 1'b1; end
        5'd4:    begin size_c = SZ_H; sext_c = 1'b1; end
        default: size_c = SZ_W;
      endcase
    end
  end

  assign mis_c = ((size_c == SZ_W) && (cpu_addr[1:0] != 2'b00)) ||
                 ((size_c == SZ_H) && cpu_addr[0]);

  assign stall = cpu_req && !cpu_done;

  // Lane extraction and extension of the read word for loads.
  always_comb begin
    case (cpu_addr[1:0])
      2'd0:    byte_c = bus_rdata[7:0];
      2'd1:    byte_c = bus_rdata[15:8];
      2'd2:    byte_c = bus_rdata[23:16];
      default: byte_c = bus_rdata[31:24];
    endcase
    half_c = cpu_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_c)
      SZ_B:    load_c = {{24{sext_c & byte_c[7]}}, byte_c};
      SZ_H:    load_c = {{16{sext_c & half_c[15]}}, half_c};
      default: load_c = bus_rdata;
    endcase
  end

  // Sub-word store: only the addressed lane is replaced in the read word.
  always_comb begin
    merge_c = bus_rdata;
    case (size_c)
      SZ_B: begin
        case (cpu_addr[1:0])
          2'd0:    merge_c[7:0]   = cpu_wdata[7:0];
          2'd1:    merge_c[15:8]  = cpu_wdata[7:0];
          2'd2:    merge_c[23:16] = cpu_wdata[7:0];
          default: merge_c[31:24] = cpu_wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (cpu_addr[1]) merge_c[31:16] = cpu_wdata[15:0];
        else             merge_c[15:0]  = cpu_wdata[15:0];
      end
      default: merge_c = cpu_wdata;
    endcase
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_hit_c;

  assign wd_hit_c = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign bus_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_rdata <= 32'd0;
      cpu_done  <= 1'b0;
      misalign  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
`ifdef LSU_BUS_TIMEOUT_EN
      bus_timeout <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
      misalign <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
      bus_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (mis_c) begin
              state     <= DONE;
              cpu_done  <= 1'b1;
              misalign  <= 1'b1;
              cpu_rdata <= 32'd0;
            end else begin
              bus_req  <= 1'b1;
              bus_addr <= {cpu_addr[31:2], 2'b00};
`ifdef LSU_BUS_TIMEOUT_EN
              wd_cnt   <= '0;
`endif
              if (cpu_we && (size_c == SZ_W)) begin
                state     <= WR;
                bus_we    <= 1'b1;
                bus_wdata <= cpu_wdata;
              end else begin
                state     <= RD;
                bus_we    <= 1'b0;
                bus_wdata <= 32'd0;
              end
            end
          end
        end
        RD: begin
          if (bus_ack) begin
`ifdef LSU_BUS_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            if (cpu_we) begin
              // Keep bus_req high so the write beat follows the read directly.
              state     <= WR;
              bus_we    <= 1'b1;
              bus_wdata <= merge_c;
            end else begin
              state     <= DONE;
              bus_req   <= 1'b0;
              cpu_done  <= 1'b1;
              cpu_rdata <= load_c;
            end
          end
`ifdef LSU_BUS_TIMEOUT_EN
          else if (wd_hit_c) begin
            state       <= DONE;
            bus_req     <= 1'b0;
            cpu_done    <= 1'b1;
            bus_timeout <= 1'b1;
            cpu_rdata   <= 32'd0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        WR: begin
          if (bus_ack) begin
            state     <= DONE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wdata <= 32'd0;
            cpu_done  <= 1'b1;
          end
`ifdef LSU_BUS_TIMEOUT_EN
          else if (wd_hit_c) begin
            state       <= DONE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_wdata   <= 32'd0;
            cpu_done    <= 1'b1;
            bus_timeout <= 1'b1;
            cpu_rdata   <= 32'd0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
